// File: rtl/sti_pkg.sv
// Shared types, length encodings and helpers for the sti_serializer slice.
package sti_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } sti_state_e;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  localparam int unsigned MAX_BITS = 32;

  // One word ready to shift: pre-aligned bits, remaining count, direction, end flag.
  typedef struct packed {
    logic [MAX_BITS-1:0] bits;
    logic [4:0]          cnt;
    logic                msb;
    logic                last;
  } sti_word_t;

  function automatic logic [4:0] len_to_cnt(input logic [1:0] len);
    logic [4:0] cnt;
    unique case (len)
      LEN_8:   cnt = 5'd7;
      LEN_16:  cnt = 5'd15;
      LEN_24:  cnt = 5'd23;
      default: cnt = 5'd31;
    endcase
    return cnt;
  endfunction

  // MSB-first words are moved up so bit N-1 sits at the top of the shift register.
  function automatic logic [MAX_BITS-1:0] msb_align(input logic [MAX_BITS-1:0] word,
                                                    input logic [4:0]          cnt);
    return word << (5'd31 - cnt);
  endfunction

endpackage

// File: rtl/sti_word_format.sv
// Combinational formatter: parallel word plus descriptor to the 32-bit word and start count.
module sti_word_format
  import sti_pkg::*;
(
  input  logic [15:0]         data_i,
  input  logic [1:0]          length_i,
  input  logic                low_i,
  input  logic                fill_i,
  output logic [MAX_BITS-1:0] word_o,
  output logic [4:0]          cnt_o
);

  always_comb begin
    word_o = '0;
    unique case (length_i)
      LEN_8:   word_o = low_i ? {24'h0, data_i[15:8]} : {24'h0, data_i[7:0]};
      LEN_16:  word_o = {16'h0, data_i};
      LEN_24:  word_o = fill_i ? {8'h0, data_i, 8'h00} : {16'h0, data_i};
      default: word_o = fill_i ? {data_i, 16'h0000} : {16'h0, data_i};
    endcase
  end

  assign cnt_o = len_to_cnt(length_i);

endmodule

// File: rtl/sti_serializer.sv
// Parallel-to-serial transmitter emitting whole bytes, with sticky end-of-stream.
// Define STI_LOAD_QUEUE_EN to add a one-entry holding register for back-to-back words.
module sti_serializer
  import sti_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] pi_data,
  input  logic [1:0]    pi_length,
  input  logic          pi_low,
  input  logic          pi_fill,
  input  logic          pi_msb,
  input  logic          pi_end,
  output logic          so_data,
  output logic          so_valid,
  output logic          busy,
  output logic          sti_end
);

  sti_state_e          state_q, state_d;
  logic [MAX_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                msb_q, msb_d;
  logic                last_q, last_d;
  logic                so_data_q, so_data_d;
  logic                so_valid_q, so_valid_d;
  logic                busy_q, busy_d;
  logic                sti_end_q, sti_end_d;

  logic [MAX_BITS-1:0] fmt_word;
  logic [4:0]          fmt_cnt;
  sti_word_t           fmt;

  sti_word_format u_word_format (
    .data_i   (pi_data),
    .length_i (pi_length),
    .low_i    (pi_low),
    .fill_i   (pi_fill),
    .word_o   (fmt_word),
    .cnt_o    (fmt_cnt)
  );

  always_comb begin
    fmt.bits = pi_msb ? msb_align(fmt_word, fmt_cnt) : fmt_word;
    fmt.cnt  = fmt_cnt;
    fmt.msb  = pi_msb;
    fmt.last = pi_end;
  end

`ifdef STI_LOAD_QUEUE_EN
  sti_word_t hold_q, hold_d;
  logic      hold_vld_q, hold_vld_d;
`endif

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    msb_d      = msb_q;
    last_d     = last_q;
    so_data_d  = 1'b0;
    so_valid_d = 1'b0;
    busy_d     = 1'b0;
    sti_end_d  = sti_end_q;
`ifdef STI_LOAD_QUEUE_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (load) begin
          sr_d    = fmt.bits;
          cnt_d   = fmt.cnt;
          msb_d   = fmt.msb;
          last_d  = fmt.last;
          state_d = StShift;
        end
      end

      StShift: begin
        so_valid_d = 1'b1;
        busy_d     = 1'b1;
        so_data_d  = msb_q ? sr_q[MAX_BITS-1] : sr_q[0];
        sr_d       = msb_q ? {sr_q[MAX_BITS-2:0], 1'b0} : {1'b0, sr_q[MAX_BITS-1:1]};
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (last_q) begin
            state_d = StDone;
          end else begin
`ifdef STI_LOAD_QUEUE_EN
            // Chain the next word straight in so so_valid has no gap.
            if (hold_vld_q) begin
              sr_d       = hold_q.bits;
              cnt_d      = hold_q.cnt;
              msb_d      = hold_q.msb;
              last_d     = hold_q.last;
              hold_vld_d = 1'b0;
            end else if (load) begin
              sr_d   = fmt.bits;
              cnt_d  = fmt.cnt;
              msb_d  = fmt.msb;
              last_d = fmt.last;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end
        end
`ifdef STI_LOAD_QUEUE_EN
        else if (load && !hold_vld_q) begin
          hold_d     = fmt;
          hold_vld_d = 1'b1;
        end
`endif
      end

      StDone: begin
        sti_end_d = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      msb_q      <= 1'b0;
      last_q     <= 1'b0;
      so_data_q  <= 1'b0;
      so_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sti_end_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      msb_q      <= msb_d;
      last_q     <= last_d;
      so_data_q  <= so_data_d;
      so_valid_q <= so_valid_d;
      busy_q     <= busy_d;
      sti_end_q  <= sti_end_d;
    end
  end

`ifdef STI_LOAD_QUEUE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  assign so_data  = so_data_q;
  assign so_valid = so_valid_q;
  assign busy     = busy_q;
  assign sti_end  = sti_end_q;

endmodule

// File: tb/tb_sti_serializer.sv
// Self-checking bench for sti_serializer: vector table, random words against a model,
// and hand-written end-of-stream, reset and back-to-back load sequences.
module tb_sti_serializer;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_low;
  logic        pi_fill;
  logic        pi_msb;
  logic        pi_end;
  logic        so_data;
  logic        so_valid;
  logic        busy;
  logic        sti_end;

  int tests;
  int fails;

  sti_serializer #(
    .DW (16),
    .CW (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .pi_data   (pi_data),
    .pi_length (pi_length),
    .pi_low    (pi_low),
    .pi_fill   (pi_fill),
    .pi_msb    (pi_msb),
    .pi_end    (pi_end),
    .so_data   (so_data),
    .so_valid  (so_valid),
    .busy      (busy),
    .sti_end   (sti_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] d;
    logic [1:0]  len;
    logic        low;
    logic        fill;
    logic        msb;
    logic [31:0] exp;
    int          n;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Expected serial stream, first emitted bit at position N-1.
  function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] len,
                                        input logic low, input logic fill, input logic msb);
    int          n;
    logic [31:0] w;
    logic [31:0] s;
    n = 8 * (int'(len) + 1);
    case (len)
      2'd0:    w = low ? {24'h0, d[15:8]} : {24'h0, d[7:0]};
      2'd1:    w = {16'h0, d};
      2'd2:    w = fill ? {16'h0, d} * 32'd256 : {16'h0, d};
      default: w = fill ? {16'h0, d} * 32'd65536 : {16'h0, d};
    endcase
    s = '0;
    for (int i = 0; i < n; i++) begin
      s = {s[30:0], (msb ? w[n-1-i] : w[i])};
    end
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_word(input logic [15:0] d, input logic [1:0] len, input logic low,
                          input logic fill, input logic msb, input logic endf,
                          output logic [31:0] got, output int n, output int lat,
                          output logic busy_ok, output logic end_last, output logic end_after);
    logic done;
    @(negedge clk);
    pi_data = d; pi_length = len; pi_low = low; pi_fill = fill; pi_msb = msb; pi_end = endf;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    // Scramble the descriptor: it must only be sampled with load.
    pi_data = 16'($urandom); pi_length = 2'($urandom); pi_low = 1'($urandom);
    pi_fill = 1'($urandom); pi_msb = 1'($urandom); pi_end = 1'($urandom);
    got = '0; n = 0; lat = -1; busy_ok = 1'b1; end_last = 1'bx; end_after = 1'bx; done = 1'b0;
    for (int c = 1; c <= 45 && !done; c++) begin
      @(negedge clk);
      if (so_valid !== busy) busy_ok = 1'b0;
      if (so_valid === 1'b1) begin
        if (lat < 0) lat = c;
        got = {got[30:0], so_data};
        n++;
        end_last = sti_end;
      end else if (lat >= 0) begin
        end_after = sti_end;
        done = 1'b1;
      end
    end
  endtask

  int          sched_cyc[3];
  logic [15:0] sched_dat[3];
  logic [1:0]  sched_len;

  task automatic run_sched(output logic [63:0] stream, output int nvalid, output int segs);
    logic prev;
    stream = '0; nvalid = 0; segs = 0; prev = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (so_valid === 1'b1) begin
        stream = {stream[62:0], so_data};
        nvalid++;
        if (!prev) segs++;
      end
      prev = (so_valid === 1'b1);
      load = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (sched_cyc[k] == c) begin
          load = 1'b1;
          pi_data = sched_dat[k]; pi_length = sched_len;
          pi_low = 1'b0; pi_fill = 1'b0; pi_msb = 1'b1; pi_end = 1'b0;
        end
      end
    end
    load = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] exp;
    logic [63:0] stream;
    int          n, lat, nvalid, segs, seen;
    logic        bok, el, ea;
    logic [15:0] rd;
    logic [1:0]  rl;
    logic        rlo, rf, rm;

    tests = 0; fails = 0;
    rst = 1'b0; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_low = 1'b0; pi_fill = 1'b0; pi_msb = 1'b0; pi_end = 1'b0;

    tbl[0] = '{16'hA5C3, 2'd0, 1'b0, 1'b0, 1'b1, 32'h000000C3, 8};
    tbl[1] = '{16'hA5C3, 2'd0, 1'b1, 1'b0, 1'b0, 32'h000000A5, 8};
    tbl[2] = '{16'hA5C3, 2'd1, 1'b0, 1'b0, 1'b1, 32'h0000A5C3, 16};
    tbl[3] = '{16'hA5C3, 2'd2, 1'b0, 1'b1, 1'b1, 32'h00A5C300, 24};
    tbl[4] = '{16'hA5C3, 2'd3, 1'b0, 1'b0, 1'b0, 32'hC3A50000, 32};
    tbl[5] = '{16'h1234, 2'd1, 1'b0, 1'b0, 1'b0, 32'h00002C48, 16};
    tbl[6] = '{16'h8001, 2'd3, 1'b0, 1'b1, 1'b1, 32'h80010000, 32};
    tbl[7] = '{16'h00F0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h000F0000, 24};
    tbl[8] = '{16'h80F7, 2'd0, 1'b1, 1'b0, 1'b1, 32'h00000080, 8};
    tbl[9] = '{16'h80F7, 2'd3, 1'b0, 1'b1, 1'b0, 32'h0000EF01, 32};

    repeat (2) @(negedge clk);
    chk("reset so_data", 64'(so_data), 64'd0);
    chk("reset so_valid", 64'(so_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset sti_end", 64'(sti_end), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_word(tbl[i].d, tbl[i].len, tbl[i].low, tbl[i].fill, tbl[i].msb, 1'b0,
               got, n, lat, bok, el, ea);
      chk($sformatf("vec%0d stream", i), 64'(got), 64'(tbl[i].exp));
      chk($sformatf("vec%0d count", i), 64'(n), 64'(tbl[i].n));
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d busy", i), 64'(bok), 64'd1);
    end

    for (int i = 0; i < 40; i++) begin
      rd = 16'($urandom); rl = 2'($urandom); rlo = 1'($urandom);
      rf = 1'($urandom); rm = 1'($urandom);
      exp = model(rd, rl, rlo, rf, rm);
      run_word(rd, rl, rlo, rf, rm, 1'b0, got, n, lat, bok, el, ea);
      chk($sformatf("rnd%0d stream", i), 64'(got), 64'(exp));
      chk($sformatf("rnd%0d count", i), 64'(n), 64'(8 * (int'(rl) + 1)));
    end

    // End-of-stream: sticky flag, later loads ignored.
    run_word(16'h5A3C, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, got, n, lat, bok, el, ea);
    chk("end stream", 64'(got), 64'h5A3C);
    chk("end count", 64'(n), 64'd16);
    chk("end flag at last bit", 64'(el), 64'd0);
    chk("end flag after last bit", 64'(ea), 64'd1);
    @(negedge clk);
    pi_data = 16'hFFFF; pi_length = 2'd0; pi_end = 1'b0; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (so_valid !== 1'b0) seen++;
    end
    chk("done ignores load", 64'(seen), 64'd0);
    chk("done sti_end held", 64'(sti_end), 64'd1);
    chk("done busy", 64'(busy), 64'd0);
    do_reset();
    chk("sti_end cleared by reset", 64'(sti_end), 64'd0);

    // Asynchronous reset in the middle of a 32-bit all-ones word.
    @(negedge clk);
    pi_data = 16'hFFFF; pi_length = 2'd3; pi_fill = 1'b0; pi_msb = 1'b0; pi_end = 1'b0;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 5; c++) begin
      @(negedge clk);
      if (so_valid === 1'b1) seen++;
    end
    chk("mid-word bits seen", 64'(seen), 64'd5);
    chk("mid-word so_data high", 64'(so_data), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst so_valid", 64'(so_valid), 64'd0);
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst so_data", 64'(so_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (so_valid !== 1'b0) seen++;
    end
    chk("no resume after reset", 64'(seen), 64'd0);
    run_word(16'h00A5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, got, n, lat, bok, el, ea);
    chk("post-reset stream", 64'(got), 64'hA5);
    chk("post-reset count", 64'(n), 64'd8);

`ifdef STI_LOAD_QUEUE_EN
    // Second load queued behind the first, third dropped while the holding slot is full.
    sched_cyc[0] = 0; sched_cyc[1] = 3; sched_cyc[2] = 5;
    sched_dat[0] = 16'h0096; sched_dat[1] = 16'h003C; sched_dat[2] = 16'h00FF;
    sched_len = 2'd0;
    run_sched(stream, nvalid, segs);
    chk("queue valid count", 64'(nvalid), 64'd16);
    chk("queue contiguous", 64'(segs), 64'd1);
    chk("queue stream", stream, 64'h963C);
    chk("queue idle after", 64'(busy), 64'd0);
`else
    // Load during shifting is ignored and does not disturb the current word.
    sched_cyc[0] = 0; sched_cyc[1] = 6; sched_cyc[2] = -1;
    sched_dat[0] = 16'hC0DE; sched_dat[1] = 16'hFFFF; sched_dat[2] = 16'h0000;
    sched_len = 2'd1;
    run_sched(stream, nvalid, segs);
    chk("busy load valid count", 64'(nvalid), 64'd16);
    chk("busy load one burst", 64'(segs), 64'd1);
    chk("busy load stream", stream, 64'hC0DE);
    chk("busy load idle after", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
